if_fetch_controller: RTL and testbench

Sequences the IF stage against a multi-cycle instruction memory with a valid/ready-style response. Issues fetch requests and drives the IF stage freeze, branch-select and pipeline flush controls. Arbitrates data-memory stalls, ID-stage hazards and EXE-stage branches into a single coherent fetch schedule. Sits between IF_Stage, the hazard unit, the EXE branch logic and the instruction memory port.

---
 rtl/if_fetch_controller_pkg.sv | 18 +
 rtl/if_fetch_controller_if.sv | 28 ++
 rtl/if_fetch_controller_wait_counter.sv | 35 +++
 rtl/if_fetch_controller.sv | 116 +++++++++++
 tb/tb_if_fetch_controller.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_controller_pkg.sv
// Shared definitions for the IF fetch controller slice.
//   fetch_state_t    : FSM state encoding (3-bit)
//   ADDR_W_DEFAULT   : default PC / branch / memory address width
//   MAX_WAIT_DEFAULT : default imem wait cycles before timeout_err is raised
package if_fetch_controller_pkg;

    localparam int unsigned ADDR_W_DEFAULT   = 32;
    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_controller_if.sv
// Instruction memory request/response port.
//   imem_req   : fetch request pulse (controller -> memory)
//   imem_addr  : fetch address, held until the next request
//   imem_ready : one-cycle response-valid pulse (memory -> controller)
// master = fetch controller side, slave = instruction memory side.
interface if_fetch_controller_if
    import if_fetch_controller_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );

endinterface

// File: rtl/if_fetch_controller_wait_counter.sv
// Saturating wait-cycle counter for the fetch controller.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count one cycle; holds at MAX once reached
//   terminal : count == MAX
module wait_counter
    import if_fetch_controller_pkg::*;
#(
    parameter int unsigned MAX = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_C)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign terminal = (cnt == MAX_C);

endmodule

// File: rtl/if_fetch_controller.sv
// IF-stage fetch sequencer for a multi-cycle instruction memory.
//   clk, rst          : clock, asynchronous active-low reset
//   pc_in             : current PC from IF_Stage
//   hazard            : ID-stage hazard, stall fetch
//   mem_stall         : MEM stage not ready, whole pipeline frozen
//   branch_taken      : EXE branch resolved taken
//   branch_address    : EXE branch target
//   imem              : instruction memory port (master side)
//   pc_freeze         : hold PC in IF_Stage
//   if_branch_taken   : IF_Stage loads branch target
//   if_branch_address : branch target passed through to IF_Stage
//   flush             : flush IF/ID and ID/EX
//   fetch_valid       : instruction accepted into IF/ID this cycle
//   timeout_err       : sticky imem timeout flag
// Priority is mem_stall > branch_taken > hazard.
module if_fetch_controller
    import if_fetch_controller_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic                  hazard,
    input  logic                  mem_stall,
    input  logic                  branch_taken,
    input  logic [ADDR_W-1:0]     branch_address,
    if_fetch_controller_if.master imem,
    output logic                  pc_freeze,
    output logic                  if_branch_taken,
    output logic [ADDR_W-1:0]     if_branch_address,
    output logic                  flush,
    output logic                  fetch_valid,
    output logic                  timeout_err
);

    fetch_state_t state;
    logic         accept_br;
    logic         fv;
    logic         wc_terminal;
    logic         tmo_q;

    // Mealy outputs. A branch seen under mem_stall is ignored; EXE re-presents it.
    always_comb begin
        accept_br = branch_taken && !mem_stall && (state != IDLE);
        fv        = 1'b0;
        case (state)
            WAIT:    fv = imem.imem_ready && !mem_stall && !hazard && !branch_taken;
            HOLD:    fv = !mem_stall && !hazard && !branch_taken;
            default: fv = 1'b0;
        endcase
    end

    assign fetch_valid       = fv;
    assign if_branch_taken   = accept_br;
    assign flush             = accept_br;
    assign pc_freeze         = !(accept_br || fv);
    assign if_branch_address = branch_address;

    // imem_req/imem_addr are registered from the REQ state, so the request
    // appears the cycle after REQ with pc_in sampled once the PC has settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            tmo_q          <= 1'b0;
        end else begin
            imem.imem_req <= (state == REQ);
            if (state == REQ) begin
                imem.imem_addr <= pc_in;
            end
            if (wc_terminal) begin
                tmo_q <= 1'b1;
            end
            case (state)
                IDLE: state <= REQ;
                REQ:  state <= accept_br ? DROP : WAIT;
                WAIT: begin
                    if (accept_br) begin
                        state <= imem.imem_ready ? REQ : DROP;
                    end else if (imem.imem_ready) begin
                        state <= fv ? REQ : HOLD;
                    end
                end
                DROP: begin
                    if (imem.imem_ready) begin
                        state <= REQ;
                    end
                end
                HOLD: begin
                    if (accept_br || fv) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wait_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == REQ),
        .en       ((state == WAIT) || (state == DROP)),
        .terminal (wc_terminal)
    );

    // Terminal is OR-ed in so the flag rises in the same cycle the count
    // reaches MAX_WAIT; tmo_q keeps it after the counter is cleared.
    assign timeout_err = tmo_q || wc_terminal;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller: a cycle-by-cycle vector table
// followed by hand-written timeout and asynchronous-reset sequences.
module tb_if_fetch_controller;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        hazard;
    logic        mem_stall;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        pc_freeze;
    logic        if_branch_taken;
    logic [31:0] if_branch_address;
    logic        flush;
    logic        fetch_valid;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_controller_if #(.ADDR_W(32)) imem_bus ();

    if_fetch_controller #(
        .ADDR_W   (32),
        .MAX_WAIT (15)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_in             (pc_in),
        .hazard            (hazard),
        .mem_stall         (mem_stall),
        .branch_taken      (branch_taken),
        .branch_address    (branch_address),
        .imem              (imem_bus),
        .pc_freeze         (pc_freeze),
        .if_branch_taken   (if_branch_taken),
        .if_branch_address (if_branch_address),
        .flush             (flush),
        .fetch_valid       (fetch_valid),
        .timeout_err       (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [31:0] pc;
        logic        hz;
        logic        ms;
        logic        bt;
        logic [31:0] ba;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_frz;
        logic        e_bt;
        logic        e_fl;
        logic        e_fv;
        logic        e_to;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    function automatic vec_t v(input logic r, input logic [31:0] pc, input logic hz,
                               input logic ms, input logic bt, input logic [31:0] ba,
                               input logic rdy, input logic e_req, input logic [31:0] e_addr,
                               input logic e_frz, input logic e_bt, input logic e_fl,
                               input logic e_fv, input logic e_to);
        vec_t t;
        t.r = r; t.pc = pc; t.hz = hz; t.ms = ms; t.bt = bt; t.ba = ba; t.rdy = rdy;
        t.e_req = e_req; t.e_addr = e_addr; t.e_frz = e_frz; t.e_bt = e_bt;
        t.e_fl = e_fl; t.e_fv = e_fv; t.e_to = e_to;
        return t;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t);
        rst                 = t.r;
        pc_in               = t.pc;
        hazard              = t.hz;
        mem_stall           = t.ms;
        branch_taken        = t.bt;
        branch_address      = t.ba;
        imem_bus.imem_ready = t.rdy;
    endtask

    task automatic check_vec(input int i, input vec_t t);
        chk1 ($sformatf("v%0d imem_req", i),          imem_bus.imem_req,  t.e_req);
        chk32($sformatf("v%0d imem_addr", i),         imem_bus.imem_addr, t.e_addr);
        chk1 ($sformatf("v%0d pc_freeze", i),         pc_freeze,          t.e_frz);
        chk1 ($sformatf("v%0d if_branch_taken", i),   if_branch_taken,    t.e_bt);
        chk1 ($sformatf("v%0d flush", i),             flush,              t.e_fl);
        chk1 ($sformatf("v%0d fetch_valid", i),       fetch_valid,        t.e_fv);
        chk1 ($sformatf("v%0d timeout_err", i),       timeout_err,        t.e_to);
        chk32($sformatf("v%0d if_branch_address", i), if_branch_address,  t.ba);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_in = '0; hazard = 1'b0; mem_stall = 1'b0;
        branch_taken = 1'b0; branch_address = '0; imem_bus.imem_ready = 1'b0;
        #1 rst = 1'b0;

        //            r  pc       hz ms bt ba       rdy | req addr     frz bt fl fv to
        tbl[0]  = v(0, 32'h000, 0, 0, 0, 32'h000, 0,   0, 32'h000, 1, 0, 0, 0, 0); // reset
        tbl[1]  = v(1, 32'h000, 0, 0, 0, 32'h000, 0,   0, 32'h000, 1, 0, 0, 0, 0); // IDLE
        tbl[2]  = v(1, 32'h000, 0, 0, 0, 32'h000, 0,   0, 32'h000, 1, 0, 0, 0, 0); // REQ
        tbl[3]  = v(1, 32'h000, 0, 0, 0, 32'h000, 0,   1, 32'h000, 1, 0, 0, 0, 0); // WAIT req
        tbl[4]  = v(1, 32'h000, 0, 0, 0, 32'h000, 0,   0, 32'h000, 1, 0, 0, 0, 0);
        tbl[5]  = v(1, 32'h000, 0, 0, 0, 32'h000, 1,   0, 32'h000, 0, 0, 0, 1, 0); // fetch
        tbl[6]  = v(1, 32'h004, 0, 0, 0, 32'h000, 0,   0, 32'h000, 1, 0, 0, 0, 0); // REQ
        tbl[7]  = v(1, 32'h004, 0, 0, 0, 32'h000, 0,   1, 32'h004, 1, 0, 0, 0, 0);
        tbl[8]  = v(1, 32'h004, 0, 0, 0, 32'h000, 0,   0, 32'h004, 1, 0, 0, 0, 0);
        tbl[9]  = v(1, 32'h004, 0, 0, 0, 32'h000, 1,   0, 32'h004, 0, 0, 0, 1, 0); // fetch
        tbl[10] = v(1, 32'h008, 0, 0, 0, 32'h000, 0,   0, 32'h004, 1, 0, 0, 0, 0); // REQ
        tbl[11] = v(1, 32'h008, 0, 0, 0, 32'h000, 0,   1, 32'h008, 1, 0, 0, 0, 0);
        tbl[12] = v(1, 32'h008, 1, 0, 0, 32'h000, 0,   0, 32'h008, 1, 0, 0, 0, 0); // hazard
        tbl[13] = v(1, 32'h008, 1, 0, 0, 32'h000, 1,   0, 32'h008, 1, 0, 0, 0, 0); // ->HOLD
        tbl[14] = v(1, 32'h008, 1, 0, 0, 32'h000, 0,   0, 32'h008, 1, 0, 0, 0, 0); // HOLD
        tbl[15] = v(1, 32'h008, 0, 0, 0, 32'h000, 0,   0, 32'h008, 0, 0, 0, 1, 0); // release
        tbl[16] = v(1, 32'h00C, 0, 0, 0, 32'h000, 0,   0, 32'h008, 1, 0, 0, 0, 0); // REQ
        tbl[17] = v(1, 32'h00C, 0, 0, 0, 32'h000, 0,   1, 32'h00C, 1, 0, 0, 0, 0);
        tbl[18] = v(1, 32'h00C, 0, 0, 1, 32'h040, 0,   0, 32'h00C, 0, 1, 1, 0, 0); // br ->DROP
        tbl[19] = v(1, 32'h040, 0, 0, 0, 32'h000, 1,   0, 32'h00C, 1, 0, 0, 0, 0); // late rdy
        tbl[20] = v(1, 32'h040, 0, 0, 0, 32'h000, 0,   0, 32'h00C, 1, 0, 0, 0, 0); // REQ
        tbl[21] = v(1, 32'h040, 0, 0, 0, 32'h000, 0,   1, 32'h040, 1, 0, 0, 0, 0);
        tbl[22] = v(1, 32'h040, 0, 1, 1, 32'h080, 0,   0, 32'h040, 1, 0, 0, 0, 0); // br+stall
        tbl[23] = v(1, 32'h040, 0, 0, 1, 32'h080, 0,   0, 32'h040, 0, 1, 1, 0, 0); // re-present
        tbl[24] = v(1, 32'h080, 0, 0, 0, 32'h000, 1,   0, 32'h040, 1, 0, 0, 0, 0); // DROP rdy
        tbl[25] = v(1, 32'h080, 0, 0, 0, 32'h000, 0,   0, 32'h040, 1, 0, 0, 0, 0); // REQ
        tbl[26] = v(1, 32'h080, 0, 0, 0, 32'h000, 0,   1, 32'h080, 1, 0, 0, 0, 0);
        tbl[27] = v(1, 32'h080, 0, 1, 0, 32'h000, 1,   0, 32'h080, 1, 0, 0, 0, 0); // ->HOLD
        tbl[28] = v(1, 32'h080, 0, 1, 0, 32'h000, 0,   0, 32'h080, 1, 0, 0, 0, 0); // HOLD
        tbl[29] = v(1, 32'h080, 0, 0, 1, 32'h100, 0,   0, 32'h080, 0, 1, 1, 0, 0); // br ->REQ
        tbl[30] = v(1, 32'h100, 0, 0, 1, 32'h200, 0,   0, 32'h080, 0, 1, 1, 0, 0); // br in REQ
        tbl[31] = v(1, 32'h200, 0, 0, 1, 32'h300, 0,   1, 32'h100, 0, 1, 1, 0, 0); // br in DROP
        tbl[32] = v(1, 32'h300, 0, 0, 0, 32'h000, 1,   0, 32'h100, 1, 0, 0, 0, 0); // DROP rdy
        tbl[33] = v(1, 32'h300, 0, 0, 0, 32'h000, 1,   0, 32'h100, 1, 0, 0, 0, 0); // spurious
        tbl[34] = v(1, 32'h300, 0, 0, 0, 32'h000, 1,   1, 32'h300, 0, 0, 0, 1, 0); // 1-cyc rsp
        tbl[35] = v(1, 32'h304, 0, 0, 0, 32'h000, 0,   0, 32'h300, 1, 0, 0, 0, 0); // REQ

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            check_vec(i, tbl[i]);
            @(posedge clk);
            #1;
        end

        // Timeout: response withheld 20 wait cycles, then delivered.
        for (int w = 0; w <= 20; w++) begin
            pc_in = 32'h304;
            branch_taken = 1'b0;
            branch_address = '0;
            imem_bus.imem_ready = (w == 20);
            @(negedge clk);
            chk1($sformatf("tmo w%0d imem_req", w),    imem_bus.imem_req, (w == 0));
            chk1($sformatf("tmo w%0d timeout_err", w), timeout_err,       (w >= 15));
            chk1($sformatf("tmo w%0d fetch_valid", w), fetch_valid,       (w == 20));
            chk1($sformatf("tmo w%0d pc_freeze", w),   pc_freeze,         (w != 20));
            @(posedge clk);
            #1;
        end

        pc_in = 32'h308;
        imem_bus.imem_ready = 1'b0;
        @(negedge clk);
        chk1("tmo sticky in REQ", timeout_err, 1'b1);
        chk1("tmo REQ imem_req", imem_bus.imem_req, 1'b0);
        @(posedge clk);
        #2;
        chk1("pre-rst imem_req", imem_bus.imem_req, 1'b1);
        chk32("pre-rst imem_addr", imem_bus.imem_addr, 32'h308);
        chk1("pre-rst timeout_err", timeout_err, 1'b1);

        // Asynchronous reset mid-WAIT, checked before any clock edge.
        branch_taken = 1'b1;
        branch_address = 32'h77;
        imem_bus.imem_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk1("arst imem_req", imem_bus.imem_req, 1'b0);
        chk32("arst imem_addr", imem_bus.imem_addr, 32'h0);
        chk1("arst timeout_err", timeout_err, 1'b0);
        chk1("arst pc_freeze", pc_freeze, 1'b1);
        chk1("arst if_branch_taken", if_branch_taken, 1'b0);
        chk1("arst flush", flush, 1'b0);
        chk1("arst fetch_valid", fetch_valid, 1'b0);

        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk1("idle br ignored", if_branch_taken, 1'b0);
        chk1("idle flush", flush, 1'b0);
        chk1("idle pc_freeze", pc_freeze, 1'b1);
        chk1("idle fetch_valid", fetch_valid, 1'b0);

        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        branch_address = '0;
        imem_bus.imem_ready = 1'b0;
        pc_in = 32'h500;
        @(negedge clk);
        chk1("post-rst REQ imem_req", imem_bus.imem_req, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("post-rst WAIT imem_req", imem_bus.imem_req, 1'b1);
        chk32("post-rst imem_addr", imem_bus.imem_addr, 32'h500);
        chk1("post-rst timeout_err", timeout_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
